// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: run enable in, sync/coordinate/strobe outputs back.
interface vga_timing_gen_if #(
  parameter int unsigned CW = 11
);
  logic          en;
  logic          h_sync;
  logic          v_sync;
  logic          de;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          pix_tick;
  logic          line_start;
  logic          frame_start;

  // Timing generator side
  modport master (
    input  en,
    output h_sync, v_sync, de, x, y, pix_tick, line_start, frame_start
  );

  // Pixel pipeline side
  modport slave (
    output en,
    input  h_sync, v_sync, de, x, y, pix_tick, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA-style timing generator with integrated pixel-clock divider.
// All outputs are registered from the pre-increment counters, so every output
// carries the same 1-clk latency and describes the same pixel.
module vga_timing_gen #(
  parameter int unsigned H_PW    = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned V_PW    = 2,
  parameter int unsigned V_BP    = 33,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned H_POL   = 0,
  parameter int unsigned V_POL   = 0,
  parameter int unsigned CLK_DIV = 1,
  parameter int unsigned CW      = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_PW + H_BP + H_DISP + H_FP;
  localparam int unsigned V_TOTAL = V_PW + V_BP + V_DISP + V_FP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_PW);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_PW);
  localparam logic [CW-1:0] H_DE_BEG   = CW'(H_PW + H_BP);
  localparam logic [CW-1:0] H_DE_END   = CW'(H_PW + H_BP + H_DISP);
  localparam logic [CW-1:0] V_DE_BEG   = CW'(V_PW + V_BP);
  localparam logic [CW-1:0] V_DE_END   = CW'(V_PW + V_BP + V_DISP);
  localparam logic          H_ACT      = (H_POL != 0);
  localparam logic          V_ACT      = (V_POL != 0);

  // Counter width must hold every position of both axes
  if ((2 ** CW) <= H_TOTAL || (2 ** CW) <= V_TOTAL) begin : g_cw_check
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end
  if (CLK_DIV < 1) begin : g_div_check
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic [DW-1:0] div_cnt;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          tick;
  logic          de_d;
  logic [CW-1:0] x_d;
  logic [CW-1:0] y_d;

  assign tick = vga.en && (div_cnt == DIV_LAST);

  // Pixel-clock divider; frozen while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (vga.en) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end
  end

  // Raster position counters, advanced once per pixel period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Active-region decode; coordinates forced to 0 outside it
  always_comb begin
    de_d = (h_cnt >= H_DE_BEG) && (h_cnt < H_DE_END) &&
           (v_cnt >= V_DE_BEG) && (v_cnt < V_DE_END);
    x_d  = de_d ? (h_cnt - H_DE_BEG) : '0;
    y_d  = de_d ? (v_cnt - V_DE_BEG) : '0;
  end

  // Output registers, loaded every clk from the current position and tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga.h_sync      <= ~H_ACT;
      vga.v_sync      <= ~V_ACT;
      vga.de          <= 1'b0;
      vga.x           <= '0;
      vga.y           <= '0;
      vga.pix_tick    <= 1'b0;
      vga.line_start  <= 1'b0;
      vga.frame_start <= 1'b0;
    end else begin
      vga.h_sync      <= (h_cnt < H_SYNC_END) ? H_ACT : ~H_ACT;
      vga.v_sync      <= (v_cnt < V_SYNC_END) ? V_ACT : ~V_ACT;
      vga.de          <= de_d;
      vga.x           <= x_d;
      vga.y           <= y_d;
      vga.pix_tick    <= tick;
      vga.line_start  <= tick && (h_cnt == '0);
      vga.frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four configurations run side by side against an
// arithmetic raster model (pixel index -> position), with random run-enable.
module tb_vga_timing_gen;

  typedef struct {
    int hpw, hbp, hdisp, hfp, vpw, vbp, vdisp, vfp, div;
    bit hpol, vpol;
  } mode_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en [4];
  logic [27:0] obs [4];
  mode_t       modes [4];
  longint      e [4];
  longint      dis [4];
  longint      last [4];
  longint      base [4];
  longint      cyc;
  int          de_cnt3;
  int          last_x3;
  int          nchecks = 0;
  int          nerrors = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(11)) vga0 ();
  vga_timing_gen_if #(.CW(11)) vga1 ();
  vga_timing_gen_if #(.CW(11)) vga2 ();
  vga_timing_gen_if #(.CW(11)) vga3 ();

  assign vga0.en = en[0];
  assign vga1.en = en[1];
  assign vga2.en = en[2];
  assign vga3.en = en[3];

  // {h_sync, v_sync, de, x, y, pix_tick, line_start, frame_start}
  assign obs[0] = {vga0.h_sync, vga0.v_sync, vga0.de, vga0.x, vga0.y,
                   vga0.pix_tick, vga0.line_start, vga0.frame_start};
  assign obs[1] = {vga1.h_sync, vga1.v_sync, vga1.de, vga1.x, vga1.y,
                   vga1.pix_tick, vga1.line_start, vga1.frame_start};
  assign obs[2] = {vga2.h_sync, vga2.v_sync, vga2.de, vga2.x, vga2.y,
                   vga2.pix_tick, vga2.line_start, vga2.frame_start};
  assign obs[3] = {vga3.h_sync, vga3.v_sync, vga3.de, vga3.x, vga3.y,
                   vga3.pix_tick, vga3.line_start, vga3.frame_start};

  vga_timing_gen #(
    .H_PW(4), .H_BP(2), .H_DISP(8), .H_FP(2), .V_PW(1), .V_BP(1), .V_DISP(4), .V_FP(1),
    .H_POL(0), .V_POL(0), .CLK_DIV(1), .CW(11)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .vga(vga0));

  vga_timing_gen #(
    .H_PW(4), .H_BP(2), .H_DISP(8), .H_FP(2), .V_PW(1), .V_BP(1), .V_DISP(4), .V_FP(1),
    .H_POL(0), .V_POL(0), .CLK_DIV(3), .CW(11)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .vga(vga1));

  vga_timing_gen #(
    .H_PW(4), .H_BP(2), .H_DISP(8), .H_FP(2), .V_PW(1), .V_BP(1), .V_DISP(4), .V_FP(1),
    .H_POL(1), .V_POL(1), .CLK_DIV(1), .CW(11)
  ) u_dut2 (.clk(clk), .rst_n(rst_n), .vga(vga2));

  vga_timing_gen u_dut3 (.clk(clk), .rst_n(rst_n), .vga(vga3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nchecks++;
    if (got !== want) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Expected outputs after an edge, given e enabled clks seen before that edge
  function automatic logic [27:0] model(input mode_t m, input longint ev, input logic en_now);
    longint ht, vt, p, h, v;
    bit tick, de, hs, vs, ls, fs;
    logic [10:0] xv, yv;
    ht   = m.hpw + m.hbp + m.hdisp + m.hfp;
    vt   = m.vpw + m.vbp + m.vdisp + m.vfp;
    p    = ev / m.div;
    tick = en_now && ((ev % m.div) == m.div - 1);
    h    = p % ht;
    v    = (p / ht) % vt;
    de   = (h >= m.hpw + m.hbp) && (h < m.hpw + m.hbp + m.hdisp) &&
           (v >= m.vpw + m.vbp) && (v < m.vpw + m.vbp + m.vdisp);
    xv   = de ? 11'(h - (m.hpw + m.hbp)) : 11'd0;
    yv   = de ? 11'(v - (m.vpw + m.vbp)) : 11'd0;
    hs   = (h < m.hpw) ? m.hpol : !m.hpol;
    vs   = (v < m.vpw) ? m.vpol : !m.vpol;
    ls   = tick && (h == 0);
    fs   = ls && (v == 0);
    return {hs, vs, de, xv, yv, tick, ls, fs};
  endfunction

  function automatic logic [27:0] rst_val(input mode_t m);
    return {!m.hpol, !m.vpol, 26'd0};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      e[i]    = 0;
      dis[i]  = 0;
      last[i] = -1;
    end
    de_cnt3 = 0;
    last_x3 = -1;
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < 4; i++) check($sformatf("%s%0d", tag, i), 32'(obs[i]), 32'(rst_val(modes[i])));
  endtask

  // One clk: advance model, compare all outputs, then interval monitors
  task automatic step();
    logic [27:0] exp_v [4];
    logic        strobe;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) begin
      exp_v[i] = model(modes[i], e[i], en[i]);
      if (en[i]) e[i]++;
      else dis[i]++;
    end
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("out%0d", i), 32'(obs[i]), 32'(exp_v[i]));
    for (int i = 0; i < 4; i++) begin
      strobe = (i == 3) ? obs[i][1] : obs[i][0];
      if (strobe) begin
        if (last[i] >= 0)
          check((i == 3) ? "line_period3" : $sformatf("frame_period%0d", i),
                32'(cyc - last[i]), 32'(base[i] + dis[i]));
        last[i] = cyc;
        dis[i]  = 0;
      end
    end
    // Default mode: 640 active pixels per line, ending at x=639
    if (obs[3][1]) begin
      if (de_cnt3 != 0) begin
        check("line_de3", 32'(de_cnt3), 32'd640);
        check("last_x3", 32'(last_x3), 32'd639);
      end
      de_cnt3 = 0;
    end
    if (obs[3][25] && obs[3][2]) begin
      de_cnt3++;
      last_x3 = int'(obs[3][24:14]);
    end
  endtask

  initial begin
    bit found;
    modes[0] = '{4, 2, 8, 2, 1, 1, 4, 1, 1, 1'b0, 1'b0};
    modes[1] = '{4, 2, 8, 2, 1, 1, 4, 1, 3, 1'b0, 1'b0};
    modes[2] = '{4, 2, 8, 2, 1, 1, 4, 1, 1, 1'b1, 1'b1};
    modes[3] = '{96, 48, 640, 16, 2, 33, 480, 10, 1, 1'b0, 1'b0};
    base[0] = 112;
    base[1] = 336;
    base[2] = 112;
    base[3] = 800;
    cyc = 0;
    clear_model();
    for (int i = 0; i < 4; i++) en[i] = 1'b1;
    rst_n = 1'b0;
    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release: position (0,0) with all strobes
    step();
    check("first_fs0", 32'(obs[0][0]), 32'd1);
    check("first_hs0", 32'(obs[0][27]), 32'd0);
    check("first_hs2", 32'(obs[2][27]), 32'd1);

    // Free-running
    for (int k = 0; k < 800; k++) step();

    // Hold at x=3 for 5 clks on the small mode
    found = 0;
    for (int k = 0; k < 300 && !found; k++) begin
      step();
      if (obs[0][25] && obs[0][24:14] == 11'd2) found = 1;
    end
    if (!found) check("wait_x2", 32'd0, 32'd1);
    en[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_x", 32'(obs[0][24:14]), 32'd3);
      check("hold_strobes", 32'(obs[0][2:0]), 32'd0);
    end
    en[0] = 1'b1;
    step();
    step();
    check("resume_x", 32'(obs[0][24:14]), 32'd4);
    for (int k = 0; k < 250; k++) step();

    // Random run-enable on every instance
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 4; i++) en[i] = ($urandom_range(0, 7) != 0);
      step();
    end
    for (int i = 0; i < 4; i++) en[i] = 1'b1;

    // Asynchronous reset mid-frame at y=2
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      step();
      if (obs[0][25] && obs[0][13:3] == 11'd2) found = 1;
    end
    if (!found) check("wait_y2", 32'd0, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(posedge clk);
    #1;
    check_reset("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    step();
    check("post_rst_fs0", 32'(obs[0][0]), 32'd1);
    check("post_rst_fs1", 32'(obs[1][0]), 32'd0);

    // Long enabled run: default mode reaches its first active lines
    for (int k = 0; k < 30000; k++) step();

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised successor to the fixed 640x480 sync generator. It produces horizontal and vertical sync, a display-enable flag, pixel coordinates and line/frame start strobes for any VGA-style mode. Programmable porches, sync polarity and an integrated pixel-clock divider let it run from the system clock. It sits between the clock source and the pixel/framebuffer pipeline; all outputs are registered and mutually aligned.

## Interface
Parameters:
- H_PW, 96: horizontal sync pulse width in pixels
- H_BP, 48: horizontal back porch in pixels
- H_DISP, 640: horizontal active pixels
- H_FP, 16: horizontal front porch in pixels
- V_PW, 2: vertical sync pulse width in lines
- V_BP, 33: vertical back porch in lines
- V_DISP, 480: vertical active lines
- V_FP, 10: vertical front porch in lines
- H_POL, 0: h_sync active level (0 = active-low)
- V_POL, 0: v_sync active level (0 = active-low)
- CLK_DIV, 1: clk cycles per pixel (≥1)
- CW, 11: counter/coordinate width; 2^CW must exceed both H_TOTAL and V_TOTAL, otherwise elaboration fails with $error

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  run enable; 0 freezes divider and counters
- h_sync  out  1  horizontal sync at H_POL level when active
- v_sync  out  1  vertical sync at V_POL level when active
- de  out  1  display enable; high in the active region
- x  out  CW  active column 0..H_DISP-1; 0 when de=0
- y  out  CW  active row 0..V_DISP-1; 0 when de=0
- pix_tick  out  1  one-clk strobe per pixel period
- line_start  out  1  one-clk strobe at h_cnt=0
- frame_start  out  1  one-clk strobe at h_cnt=0, v_cnt=0

## Operation
- H_TOTAL = H_PW+H_BP+H_DISP+H_FP. V_TOTAL = V_PW+V_BP+V_DISP+V_FP.
- Region order per line and per frame: sync, back porch, display, front porch. Count 0 is the first sync cycle.
- Divider div_cnt runs 0..CLK_DIV-1 while en=1. Internal tick = en && div_cnt==CLK_DIV-1. With CLK_DIV=1, tick = en.
- On tick, h_cnt increments.
  - At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - If v_cnt is at V_TOTAL-1 when h_cnt wraps, v_cnt also wraps to 0.
- Sync conditions:
  - h_sync is active iff h_cnt < H_PW.
  - v_sync is active iff v_cnt < V_PW.
  - The output level is the POL value when active and its inverse otherwise.
- de = (H_PW+H_BP ≤ h_cnt < H_PW+H_BP+H_DISP) && (V_PW+V_BP ≤ v_cnt < V_PW+V_BP+V_DISP).
- Coordinates: x = h_cnt-(H_PW+H_BP) and y = v_cnt-(V_PW+V_BP) when de=1. Both are forced to 0 otherwise, so no wrapped negatives.
- Strobes:
  - pix_tick = tick.
  - line_start = tick && h_cnt==0.
  - frame_start = tick && h_cnt==0 && v_cnt==0.
- en=0:
  - div_cnt, h_cnt and v_cnt hold.
  - Registered level outputs keep reflecting the held position.
  - All strobes are 0.
  - Counting resumes from the held state when en returns to 1.

## Timing
- Every output is a register loaded each clk from the current (pre-increment) counters and tick. Latency is 1 clk from counter state to outputs, identical for all outputs.
- In the cycle where pix_tick=1, h_sync, v_sync, de, x and y describe the same pixel as the strobes.
- With CLK_DIV>1, level outputs are stable for CLK_DIV clks per pixel. Strobes are 1 clk wide and occur in the last clk of each pixel period.
- Reset (asynchronous assert, any time, including mid-frame):
  - div_cnt, h_cnt and v_cnt go to 0.
  - h_sync = ~H_POL and v_sync = ~V_POL (inactive).
  - de, x, y and all strobes go to 0.
- Reset release with en=1 and CLK_DIV=1:
  - The first clk edge loads position (0,0): both syncs active, pix_tick, line_start and frame_start all 1.
- Periods at default parameters and CLK_DIV=1:
  - line_start period 800 clks.
  - frame_start period 420000 clks.
  - h_sync active for 96 consecutive clks per line.
  - v_sync active for 1600 clks per frame.

## Test plan
- Small mode (H 4/2/8/2, V 1/1/4/1, CLK_DIV=1, en=1) after reset:
  - h_sync low 4 of every 16 clks.
  - de high 8 clks per line on lines 2..5 only.
  - x steps 0..7 and y steps 0..3.
  - frame_start every 112 clks.
- Same mode with CLK_DIV=3:
  - Each pixel's outputs are held 3 clks.
  - pix_tick every 3rd clk.
  - frame_start every 336 clks.
- H_POL=1, V_POL=1:
  - h_sync high for the 4-clk sync window.
  - v_sync high for 16 clks per frame.
  - Both low at reset.
- en pulsed low for 5 clks mid-line at x=3:
  - Outputs hold x=3 and strobes stay 0.
  - After en returns, x continues to 4.
  - The frame period is lengthened by exactly 5 clks.
- rst_n asserted asynchronously mid-frame (between clk edges) at y=2:
  - All outputs go to reset values immediately, without a clk edge.
  - After release, frame_start occurs on the first clk.
- Default 640x480 parameters, CLK_DIV=1:
  - line_start interval 800.
  - frame_start interval 420000.
  - de count per frame 307200.
  - Final active pixel is x=639, y=479.
